// File: rtl/iq_upconverter.sv
// iq_upconverter: I*cos - Q*sin quadrature upconverter with zero-order-held baseband input
// Ports:
//   i_clk, reset (async, active-low), i_ce (shared with the NCO)
//   i_cos/i_sin   : signed NCO samples
//   i_bb_i/i_bb_q : signed baseband symbol, offered with i_bb_valid / o_bb_ready
//   o_sample      : rounded, saturated modulated output
//   o_valid       : o_sample came from a live (held) symbol
//   o_underrun    : sticky, a hold period ended with no new symbol
module iq_upconverter #(
  parameter int HOLD_CYCLES = 8,
  parameter int BB_W        = 16,
  parameter int NCO_W       = 17,
  parameter int OUT_W       = 17
) (
  input  logic                    i_clk,
  input  logic                    reset,
  input  logic                    i_ce,
  input  logic signed [NCO_W-1:0] i_cos,
  input  logic signed [NCO_W-1:0] i_sin,
  input  logic signed [BB_W-1:0]  i_bb_i,
  input  logic signed [BB_W-1:0]  i_bb_q,
  input  logic                    i_bb_valid,
  output logic                    o_bb_ready,
  output logic signed [OUT_W-1:0] o_sample,
  output logic                    o_valid,
  output logic                    o_underrun
);
  localparam int CW  = $clog2(HOLD_CYCLES);
  localparam int P_W = BB_W + NCO_W;
  localparam int S_W = P_W + 1;
  localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);
  localparam logic signed [S_W-1:0] MAXV = S_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [S_W-1:0] MINV = -MAXV - S_W'(1);
  localparam logic signed [S_W-1:0] HALF = S_W'(2 ** (BB_W - 2));
  typedef enum logic {IDLE, RUN} state_e;
  state_e                  state_q;
  logic [CW-1:0]           cnt_q;
  logic signed [BB_W-1:0]  sym_i_q, sym_q_q;
  logic                    underrun_q;
  logic signed [NCO_W-1:0] cos1_q, sin1_q;
  logic signed [BB_W-1:0]  i1_q, q1_q;
  logic                    tag1_q, tag2_q, tag3_q, valid_q;
  logic signed [P_W-1:0]   pi2_q, pq2_q;
  logic signed [S_W-1:0]   sum3_q, rnd_d, sh_d;
  logic signed [OUT_W-1:0] sample_d, sample_q;
  wire term = state_q == RUN && cnt_q == LAST;
  assign o_bb_ready = state_q == IDLE || term;
  assign o_sample   = sample_q;
  assign o_valid    = valid_q;
  assign o_underrun = underrun_q;
  // Symbol hold FSM: a new symbol at terminal count replaces the old one with no gap.
  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sym_i_q    <= '0;
      sym_q_q    <= '0;
      underrun_q <= 1'b0;
    end else if (i_ce) begin
      if (i_bb_valid && o_bb_ready) begin
        state_q <= RUN;
        cnt_q   <= '0;
        sym_i_q <= i_bb_i;
        sym_q_q <= i_bb_q;
      end else if (term) begin
        state_q    <= IDLE;
        cnt_q      <= '0;
        sym_i_q    <= '0;
        sym_q_q    <= '0;
        underrun_q <= 1'b1;
      end else if (state_q == RUN) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end
  // Round half-up, then drop BB_W-1 fraction bits and clamp to the DAC range.
  always_comb begin
    rnd_d    = sum3_q + HALF;
    sh_d     = rnd_d >>> (BB_W - 1);
    sample_d = sh_d > MAXV ? OUT_W'(MAXV) : sh_d < MINV ? OUT_W'(MINV) : OUT_W'(sh_d);
  end
  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      cos1_q   <= '0;
      sin1_q   <= '0;
      i1_q     <= '0;
      q1_q     <= '0;
      tag1_q   <= 1'b0;
      pi2_q    <= '0;
      pq2_q    <= '0;
      tag2_q   <= 1'b0;
      sum3_q   <= '0;
      tag3_q   <= 1'b0;
      sample_q <= '0;
      valid_q  <= 1'b0;
    end else if (i_ce) begin
      cos1_q   <= i_cos;
      sin1_q   <= i_sin;
      i1_q     <= sym_i_q;
      q1_q     <= sym_q_q;
      tag1_q   <= state_q == RUN;
      pi2_q    <= P_W'(i1_q) * P_W'(cos1_q);
      pq2_q    <= P_W'(q1_q) * P_W'(sin1_q);
      tag2_q   <= tag1_q;
      sum3_q   <= S_W'(pi2_q) - S_W'(pq2_q);
      tag3_q   <= tag2_q;
      sample_q <= sample_d;
      valid_q  <= tag3_q;
    end
  end
endmodule

// File: doc/iq_upconverter.md
# iq_upconverter

Digital quadrature upconverter sitting directly downstream of the `dds` NCO. It multiplies a held baseband I/Q symbol stream by the DDS cosine and sine samples, forms I·cos − Q·sin, then rounds and saturates the result to the DAC sample width. Baseband symbols enter through a valid/ready handshake and are zero-order held for a fixed number of clock-enable cycles. Every datapath stage advances only on `i_ce`, the same enable that drives the NCO.

## Interface
- `HOLD_CYCLES`, 8: clock-enable cycles each baseband symbol is held; legal range ≥ 2.
- `BB_W`, 16: signed baseband I/Q width.
- `NCO_W`, 17: signed DDS cos/sin width; matches the `dds` output.
- `OUT_W`, 17: signed output sample width.
- `i_clk`  in  1  single clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `i_ce`  in  1  clock enable, shared with `dds`.
- `i_cos`  in  NCO_W  signed DDS cosine sample.
- `i_sin`  in  NCO_W  signed DDS sine sample.
- `i_bb_i`  in  BB_W  signed baseband in-phase value.
- `i_bb_q`  in  BB_W  signed baseband quadrature value.
- `i_bb_valid`  in  1  baseband symbol offered.
- `o_bb_ready`  out  1  block will accept a symbol at this edge if `i_ce`=1.
- `o_sample`  out  OUT_W  signed modulated output.
- `o_valid`  out  1  `o_sample` was produced from a live symbol.
- `o_underrun`  out  1  sticky flag: a hold period expired with no new symbol.

## Operation
- **States:**
  - IDLE: no symbol held; symbol registers hold zero.
  - RUN: a symbol is held; hold counter `cnt` counts 0..HOLD_CYCLES−1.
- **Ready:** `o_bb_ready` = (state==IDLE) OR (state==RUN AND `cnt`==HOLD_CYCLES−1). It is combinational from state and does not depend on `i_ce` or `i_bb_valid`.
- **Transfer:** occurs on a rising edge with `i_bb_valid` & `o_bb_ready` & `i_ce`. It loads the symbol registers, sets `cnt`=0 and sets state=RUN.
- **RUN, non-terminal count:** with `i_ce` high and `cnt`<HOLD_CYCLES−1, `cnt` increments.
- **RUN, terminal count without data:** `cnt`==HOLD_CYCLES−1, `i_ce` high and no valid symbol:
  - symbol registers clear to 0 and state goes to IDLE;
  - `o_underrun` sets to 1 and stays set until reset.
- **Start-up:** IDLE at start-up never sets `o_underrun`.
- **Clock enable low:** state, `cnt`, symbol registers and all pipeline stages hold.
- **Pipeline (one register per stage, all gated by `i_ce`):**
  - S1: capture `i_cos`, `i_sin`, symbol I/Q, and tag = (state==RUN).
  - S2: p_i = I·cos and p_q = Q·sin, each full precision BB_W+NCO_W bits.
  - S3: sum = p_i − p_q, BB_W+NCO_W+1 bits, no overflow possible.
  - S4: r = (sum + 2^(BB_W−2)) >>> (BB_W−1), arithmetic shift with round-half-up. Saturate r to [−2^(OUT_W−1), 2^(OUT_W−1)−1] and drive it on `o_sample`.
- **Tag:** the tag travels with the data through the pipeline and drives `o_valid` at S4.
- **Reset:** asynchronous, active-low, takes effect immediately regardless of `i_ce`. On exit from reset the block is in IDLE with `cnt` = 0.

## Timing
- **Reset values:** `o_sample`=0, `o_valid`=0, `o_underrun`=0, `o_bb_ready`=1 (IDLE). All pipeline registers and the tag are 0.
- **Latency:**
  - Datapath: DDS sample on `i_cos`/`i_sin` at ce-edge n appears in `o_sample` after ce-edge n+3, i.e. 4 ce-edges including capture.
  - Symbol: accepted at ce-edge k, first captured at S1 at ce-edge k+1, first visible on `o_sample` after ce-edge k+4.
- **Throughput:** back-to-back symbols sustain one per HOLD_CYCLES ce-edges with no gaps. `o_bb_ready` is high for exactly one of every HOLD_CYCLES ce-cycles in steady state.
- **Ready without clock enable:** `o_bb_ready` may be high while `i_ce`=0; no transfer occurs and the offer must be held.
- **Terminal count with new symbol:** a valid symbol at terminal count keeps state RUN, leaves `o_underrun` untouched and gives no zero gap.
- **Reset mid-hold:** discards the held symbol and the pipeline contents; `o_underrun` clears.
- **Output timing:** outputs change only on rising edges, after ce-edges, or asynchronously on reset.

## Test plan
- **Reset:** pulse `reset` low mid-stream with `i_ce`=1 → `o_sample`=0, `o_valid`=0, `o_underrun`=0, `o_bb_ready`=1 immediately, without waiting for a clock edge.
- **Scaling:** I=16384, Q=0, cos=65535 held constant, continuous symbols → `o_sample`=32768 with `o_valid`=1 from ce-edge k+4 onward.
- **Saturation:**
  - I=32767, Q=−32768, cos=sin=65535 → `o_sample`=65535.
  - I=−32768, Q=32767, cos=sin=65535 → `o_sample`=−65536.
- **Handshake with HOLD_CYCLES=8:** `i_bb_valid` held high with distinct symbols → exactly one transfer every 8 ce-edges, `o_underrun` stays 0, and `o_sample` tracks each symbol with 4-ce latency.
- **Underrun:** one symbol offered, then `i_bb_valid` low:
  - after 8 ce-edges → state IDLE, `o_underrun`=1 (sticky);
  - 4 ce-edges later → `o_sample`=0 and `o_valid`=0;
  - a new symbol afterwards is accepted on the next ce-edge and `o_underrun` stays 1.
- **Clock-enable gating:** toggle `i_ce` 1-of-3 cycles → `cnt`, state and `o_sample` advance only on enabled edges. Results match the always-enabled run sample-for-sample.
